// File: rtl/drop_input_ctrl_pkg.sv
// Shared definitions for the drop-game input front end: FSM states, button
// indices and the column geometry agreed with the game core.
package drop_ctrl_pkg;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = 2;

    localparam int BTN_DROP  = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int NUM_BTNS  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HOLDOFF = 2'd2
    } drop_state_e;

    // Four columns fill the 2-bit cursor exactly, so modular wrap is free.
    function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] col,
                                                  input logic             go_right);
        logic [COL_W-1:0] one;
        one = COL_W'(1);
        col_step = go_right ? (col + one) : (col - one);
    endfunction

endpackage

// File: rtl/drop_input_ctrl_btn_debounce.sv
// One push-button: 2-flop synchroniser, persistence debouncer and a
// single-cycle press strobe on the rising edge of the accepted level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = '0;
        // Counter only runs while the synchronised level disagrees; any
        // agreement restarts it, so short glitches never reach the limit.
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/drop_input_ctrl.sv
// Player-input front end: debounced buttons drive a wrapping column cursor
// and a one-shot drop request, with a holdoff while the core animates.
module drop_input_ctrl
    import drop_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLDOFF_CYCLES  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    input  logic       game_over,
    output logic [1:0] col_sel,
    output logic       drop_pulse,
    output logic       ready
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    assign btn_raw[BTN_DROP]  = btn_drop;
    assign btn_raw[BTN_LEFT]  = btn_left;
    assign btn_raw[BTN_RIGHT] = btn_right;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn_raw(btn_raw[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    drop_state_e      state_q, state_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             pulse_q, pulse_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        col_d      = col_q;
        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                // A drop takes priority and uses the cursor as it stands.
                if (press[BTN_DROP] && !game_over) begin
                    state_d = FIRE;
                end else if (press[BTN_LEFT] ^ press[BTN_RIGHT]) begin
                    col_d = col_step(col_q, press[BTN_RIGHT]);
                end
            end
            FIRE: begin
                state_d    = HOLDOFF;
                hold_cnt_d = '0;
            end
            HOLDOFF: begin
                if (hold_cnt_q >= HOLD_LAST) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
        pulse_d = (state_d == FIRE);
        ready_d = (state_d == IDLE) && !game_over;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            col_q      <= '0;
            pulse_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            col_q      <= col_d;
            pulse_q    <= pulse_d;
            ready_q    <= ready_d;
        end
    end

    assign col_sel    = col_q;
    assign drop_pulse = pulse_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_drop_input_ctrl.sv
// Self-checking bench for drop_input_ctrl with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
module tb_drop_input_ctrl;

    localparam int D    = 4;
    localparam int H    = 8;
    localparam int MAXC = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_drop = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] col_sel;
    logic       drop_pulse;
    logic       ready;

    int total = 0;
    int bad   = 0;

    drop_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_drop  (btn_drop),
        .game_over (game_over),
        .col_sel   (col_sel),
        .drop_pulse(drop_pulse),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Reference model: raw sample history per button (0=drop,1=left,2=right),
    // plus timestamps of the last drop and of the end of its holdoff.
    bit   hist [0:2][0:MAXC-1];
    logic m_acc [0:2];
    logic m_rose [0:2];
    int   m_last_tog [0:2];
    int   cyc;
    int   m_ready_edge;
    int   m_fire_edge;
    int   m_col;
    logic m_pulse;
    logic m_ready;
    int   pulses_seen = 0;
    int   pulse_col = 0;

    task automatic model_reset();
        cyc          = 0;
        m_ready_edge = -1;
        m_fire_edge  = -1000;
        m_col        = 0;
        m_pulse      = 1'b0;
        m_ready      = 1'b1;
        for (int b = 0; b < 3; b++) begin
            m_acc[b]      = 1'b0;
            m_rose[b]     = 1'b0;
            m_last_tog[b] = -1000;
        end
    endtask

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic step();
        logic raw [0:2];
        logic pr [0:2];
        bit   all_diff;
        bit   idle_before;
        bit   fire;
        logic s;
        int   e;
        @(posedge clk);
        e      = cyc;
        raw[0] = btn_drop;
        raw[1] = btn_left;
        raw[2] = btn_right;
        for (int b = 0; b < 3; b++) begin
            pr[b]     = m_rose[b];
            m_rose[b] = 1'b0;
            // New level accepted once D consecutive (2-cycle delayed) samples
            // all disagree, with no overlap into the previous acceptance.
            if (e - m_last_tog[b] >= D) begin
                all_diff = 1'b1;
                for (int j = e - D - 1; j <= e - 2; j++) begin
                    s = (j < 0) ? 1'b0 : logic'(hist[b][j]);
                    if (s == m_acc[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_rose[b]     = !m_acc[b];
                    m_acc[b]      = !m_acc[b];
                    m_last_tog[b] = e;
                end
            end
            hist[b][e] = raw[b];
        end
        idle_before = (e - 1 >= m_ready_edge);
        fire = idle_before && pr[0] && !game_over;
        if (fire) begin
            m_fire_edge  = e;
            m_ready_edge = e + 1 + H;
        end else if (idle_before && (pr[1] ^ pr[2])) begin
            m_col = pr[2] ? (m_col + 1) % 4 : (m_col + 3) % 4;
        end
        m_pulse = (m_fire_edge == e);
        m_ready = (e >= m_ready_edge) && !game_over;
        cyc++;
        #1;
        if (drop_pulse === 1'b1) begin
            pulses_seen++;
            pulse_col = int'(col_sel);
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic d, input int n);
        btn_left  = l;
        btn_right = r;
        btn_drop  = d;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; game_over = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        total++; if (col_sel !== 2'd0) begin bad++; $display("FAIL reset_col got=%0d exp=0", col_sel); end
        total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", drop_pulse); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        release_reset();
        drive(0, 0, 0, 5);
        total++; if (col_sel !== 2'd0 || drop_pulse !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL idle_after_reset got col=%0d pulse=%b ready=%b exp 0/0/1", col_sel, drop_pulse, ready);
        end
    endtask

    task automatic test_first_drop();
        int first = -1;
        int n_high = 0;
        int n_rdy_low = 0;
        btn_drop = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 6) btn_drop = 1'b0;
            if (drop_pulse === 1'b1 && first < 0) first = i;
            if (drop_pulse === 1'b1) n_high++;
            if (ready === 1'b0) n_rdy_low++;
            total++; if (drop_pulse !== m_pulse || ready !== m_ready) begin
                bad++; $display("FAIL first_drop_cycle%0d got pulse=%b ready=%b exp %b/%b", i, drop_pulse, ready, m_pulse, m_ready);
            end
        end
        total++; if (first != 7) begin bad++; $display("FAIL first_drop_latency got=%0d exp=7", first); end
        total++; if (n_high != 1) begin bad++; $display("FAIL first_drop_width got=%0d exp=1", n_high); end
        total++; if (n_rdy_low != 9) begin bad++; $display("FAIL first_drop_ready_low got=%0d exp=9", n_rdy_low); end
        total++; if (pulse_col != 0) begin bad++; $display("FAIL first_drop_col got=%0d exp=0", pulse_col); end
    endtask

    task automatic test_moves();
        int dirs [0:7] = '{1, 1, 1, 0, 1, 1, 1, 1};
        int expc [0:7] = '{1, 2, 3, 2, 3, 0, 1, 2};
        for (int m = 0; m < 8; m++) begin
            drive(logic'(dirs[m] == 0), logic'(dirs[m] == 1), 0, 6);
            drive(0, 0, 0, 10);
            total++; if (col_sel !== 2'(expc[m]) || col_sel !== 2'(m_col)) begin
                bad++; $display("FAIL move%0d got=%0d exp=%0d model=%0d", m, col_sel, expc[m], m_col);
            end
        end
    endtask

    task automatic test_glitch_and_hold();
        logic [1:0] col0;
        int p0;
        col0 = col_sel;
        drive(0, 1, 0, 3);
        drive(0, 0, 0, 12);
        total++; if (col_sel !== col0 || col_sel !== 2'(m_col)) begin
            bad++; $display("FAIL glitch_col got=%0d exp=%0d", col_sel, col0);
        end
        p0 = pulses_seen;
        drive(0, 0, 1, 50);
        drive(0, 0, 0, 20);
        total++; if (pulses_seen - p0 != 1) begin
            bad++; $display("FAIL held_drop_pulses got=%0d exp=1", pulses_seen - p0);
        end
    endtask

    task automatic test_holdoff_discard();
        int p0;
        int mp0;
        logic [1:0] col0;
        p0 = pulses_seen; col0 = col_sel; mp0 = m_col;
        drive(0, 0, 1, 2);
        drive(0, 1, 1, 2);
        drive(0, 1, 0, 2);
        drive(0, 0, 0, 3);
        drive(0, 0, 1, 4);
        drive(0, 0, 0, 20);
        total++; if (pulses_seen - p0 != 1) begin
            bad++; $display("FAIL holdoff_pulses got=%0d exp=1", pulses_seen - p0);
        end
        total++; if (col_sel !== col0 || m_col != mp0) begin
            bad++; $display("FAIL holdoff_col got=%0d exp=%0d", col_sel, col0);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        drive(1, 0, 0, 6);
        drive(0, 0, 0, 10);
        total++; if (col_sel !== 2'd1) begin bad++; $display("FAIL simul_setup_col got=%0d exp=1", col_sel); end
        p0 = pulses_seen;
        drive(0, 1, 1, 6);
        drive(0, 0, 0, 20);
        total++; if (pulses_seen - p0 != 1) begin bad++; $display("FAIL simul_pulses got=%0d exp=1", pulses_seen - p0); end
        total++; if (pulse_col != 1) begin bad++; $display("FAIL simul_pulse_col got=%0d exp=1", pulse_col); end
        total++; if (col_sel !== 2'd1 || m_col != 1) begin bad++; $display("FAIL simul_col_after got=%0d exp=1", col_sel); end
    endtask

    task automatic test_game_over();
        int p0;
        int rdy_hi = 0;
        game_over = 1'b1;
        drive(0, 0, 0, 2);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL go_ready got=%b exp=0", ready); end
        p0 = pulses_seen;
        btn_drop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) btn_drop = 1'b0;
            if (ready === 1'b1) rdy_hi++;
        end
        total++; if (pulses_seen - p0 != 0) begin bad++; $display("FAIL go_drop_pulses got=%0d exp=0", pulses_seen - p0); end
        total++; if (rdy_hi != 0) begin bad++; $display("FAIL go_ready_high got=%0d exp=0", rdy_hi); end
        drive(0, 1, 0, 6);
        drive(0, 0, 0, 10);
        total++; if (col_sel !== 2'd2 || m_col != 2) begin bad++; $display("FAIL go_move got=%0d exp=2", col_sel); end
        game_over = 1'b0;
        drive(0, 0, 0, 2);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL go_clear_ready got=%b exp=1", ready); end
    endtask

    task automatic test_reset_mid_holdoff();
        int waited = 0;
        int first = -1;
        btn_drop = 1'b1;
        while (drop_pulse !== 1'b1 && waited < 30) begin
            step();
            waited++;
            if (waited == 6) btn_drop = 1'b0;
        end
        total++; if (waited >= 30) begin bad++; $display("FAIL rst_hold_no_pulse got=none exp=pulse"); end
        btn_drop = 1'b0;
        step(); step(); step();
        total++; if (ready !== 1'b0 || col_sel !== 2'd2) begin
            bad++; $display("FAIL rst_hold_pre got ready=%b col=%0d exp 0/2", ready, col_sel);
        end
        // Reset lands mid-cycle, with drop held through release.
        #2;
        rst_n = 1'b0;
        btn_drop = 1'b1;
        #1;
        model_reset();
        total++; if (col_sel !== 2'd0 || drop_pulse !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL rst_hold_async got col=%0d pulse=%b ready=%b exp 0/0/1", col_sel, drop_pulse, ready);
        end
        release_reset();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 8) btn_drop = 1'b0;
            if (drop_pulse === 1'b1 && first < 0) first = i;
        end
        total++; if (first != 7) begin bad++; $display("FAIL rst_held_fresh_press got=%0d exp=7", first); end
        drive(0, 0, 0, 10);
    endtask

    task automatic test_random();
        int rem [0:2] = '{0, 0, 0};
        logic lv [0:2] = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lv[b]  = logic'($urandom_range(0, 1));
                    rem[b] = int'($urandom_range(1, 12));
                end
                rem[b]--;
            end
            if ($urandom_range(0, 199) == 0) game_over = ~game_over;
            btn_drop  = lv[0];
            btn_left  = lv[1];
            btn_right = lv[2];
            step();
            total++; if (drop_pulse !== m_pulse) begin bad++; $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", cyc, drop_pulse, m_pulse); end
            total++; if (ready !== m_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ready, m_ready); end
            total++; if (col_sel !== 2'(m_col)) begin bad++; $display("FAIL rand_col cyc=%0d got=%0d exp=%0d", cyc, col_sel, m_col); end
        end
        game_over = 1'b0;
        drive(0, 0, 0, 20);
    endtask

    initial begin
        test_reset();
        test_first_drop();
        test_moves();
        test_glitch_and_hold();
        test_holdoff_discard();
        test_simultaneous();
        test_game_over();
        test_reset_mid_holdoff();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drop_input_ctrl.md
# drop_input_ctrl

Player-input front end for the 2048 drop game: turns three raw push-buttons into the `col_sel` / `drop_pulse` pair consumed by `game_core_2048_drop`. Synchronises and debounces each button, keeps a wrapping column cursor, and issues exactly one single-cycle `drop_pulse` per press. Holds the column stable and rejects further drops for a fixed holdoff while the core animates the fall and merge. Sits between the board pins and the game core, in the same `clk` domain as the core.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a button level must persist before it is accepted (10 ms at 100 MHz).
- `HOLDOFF_CYCLES`, default 200: cycles after a drop during which drops and moves are ignored.
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_left`  in  1  raw button, asynchronous to `clk`, active-high.
- `btn_right`  in  1  raw button, asynchronous, active-high.
- `btn_drop`  in  1  raw button, asynchronous, active-high.
- `game_over`  in  1  from the core; blocks drops while high.
- `col_sel`  out  2  column cursor to the core.
- `drop_pulse`  out  1  single-cycle drop request to the core.
- `ready`  out  1  high when a drop press would be accepted.

## Operation
- Per button: 2-flop synchroniser, then a debouncer. The debouncer counter increments each cycle the synchronised level differs from the accepted level and clears when they match. When the counter reaches `DEBOUNCE_CYCLES`, the accepted level toggles and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` never changes the accepted level.
- Press event: one-cycle rising edge of the accepted level. Releases generate nothing. Holding a button produces no repeats.
- FSM states:
  - IDLE → FIRE on a drop press when `game_over`=0.
  - FIRE → HOLDOFF after one cycle; `drop_pulse`=1 only while in FIRE.
  - HOLDOFF → IDLE after exactly `HOLDOFF_CYCLES` cycles.
- Column moves apply only in IDLE.
  - Left: `col_sel` decrements, 0 wraps to 3.
  - Right: `col_sel` increments, 3 wraps to 0.
  - Left and right press in the same cycle: no change.
- Drop press and move press in the same IDLE cycle: the drop wins and the move is discarded. The drop uses the pre-move `col_sel`.
- `col_sel` is frozen throughout FIRE and HOLDOFF. Presses in those states are discarded, not queued.
- While `game_over`=1, drop presses are discarded and moves still work.
- `game_over` rising during HOLDOFF: the FSM finishes HOLDOFF normally.
- `ready` = (state==IDLE) && !`game_over`.
- Reset (asynchronous, any state):
  - `col_sel`=0, `drop_pulse`=0, FSM=IDLE.
  - Synchronisers, accepted levels and counters cleared.
  - `ready`=1 once released with `game_over`=0.
  - A button held through reset release must be debounced as a fresh press.

## Timing
- Let edge k be the first `clk` edge that samples a new raw level.
- Accepted level changes at edge k+1+`DEBOUNCE_CYCLES`.
- Drop: FSM enters FIRE and `drop_pulse` rises at edge k+2+`DEBOUNCE_CYCLES`. It falls one cycle later.
- Move: `col_sel` updates at edge k+2+`DEBOUNCE_CYCLES`.
- `ready` falls with `drop_pulse` and rises `1+HOLDOFF_CYCLES` cycles after `drop_pulse` rises.
- All outputs are registered; no combinational path from inputs.
- Counter widths: `$clog2(DEBOUNCE_CYCLES+1)` and `$clog2(HOLDOFF_CYCLES+1)`. Counters saturate and never wrap.

## Structure
- Package `drop_ctrl_pkg`:
  - FSM state enum (IDLE, FIRE, HOLDOFF).
  - `NUM_COLS`=4 and column width 2, shared with the game core and its bench.
- Sub-module `btn_debounce`: synchroniser, debouncer and rising-edge output, parameterised by `DEBOUNCE_CYCLES`, instantiated three times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLDOFF_CYCLES`=8.
- Reset, then raise `btn_drop` → `drop_pulse` high for exactly 1 cycle at edge k+6, `col_sel`=0, `ready` low for 9 cycles.
- Three right presses then one left press → `col_sel` goes 1, 2, 3, then 2. Four further right presses from 2 → 3, 0, 1, 2 (wrap checked).
- 3-cycle glitch on `btn_right` → `col_sel` unchanged. Drop held 50 cycles → exactly one `drop_pulse`.
- Drop press, then right press and a second drop press both within HOLDOFF → no second pulse, `col_sel` unchanged.
- Drop and right pressed in the same cycle at `col_sel`=1 → pulse with `col_sel`=1, which stays 1.
- `game_over`=1 with drop pressed → no pulse, `ready`=0, and a right press still moves the cursor. Reset asserted mid-HOLDOFF → immediate IDLE with `col_sel`=0 and `drop_pulse`=0.
